// File: rtl/wager_pkg.sv
// rtl/wager_pkg.sv - shared types, result codes and saturating add for the wager bank
package wager_pkg;

  typedef enum logic [1:0] {
    ST_BET    = 2'd0,
    ST_LOCKED = 2'd1,
    ST_PAYOUT = 2'd2
  } state_t;

  localparam logic [2:0] RES_LOSE = 3'd0;
  localparam logic [2:0] RES_PUSH = 3'd1;

  // Common width for the adder; callers zero-extend into it and keep the low bits.
  localparam int SAT_W = 32;

  typedef struct packed {
    logic [SAT_W-1:0] sum;
    logic             sat;
  } sat_res_t;

  function automatic sat_res_t sat_add(input logic [SAT_W-1:0] a,
                                       input logic [SAT_W-1:0] b,
                                       input int               width);
    logic [SAT_W:0] s;
    logic [SAT_W:0] lim;
    sat_res_t       r;
    s   = {1'b0, a} + {1'b0, b};
    lim = ((SAT_W+1)'(1) << width) - (SAT_W+1)'(1);
    if (s > lim) begin
      r.sum = lim[SAT_W-1:0];
      r.sat = 1'b1;
    end else begin
      r.sum = s[SAT_W-1:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/wager_payout_calc.sv
// rtl/wager_payout_calc.sv - wager*code payout and saturating credit to the balance
module wager_payout_calc
  import wager_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_mih,
  input  logic [WIDTH-1:0] i_wager,
  input  logic [2:0]       i_code,
  output logic [WIDTH-1:0] o_mih,
  output logic             o_sat
);

  logic [WIDTH+2:0] w_payout;
  sat_res_t         w_res;
  logic             w_unused;

  always_comb begin
    w_payout = '0;
    if (i_code == RES_LOSE)
      w_payout = '0;
    else if (i_code == RES_PUSH)
      w_payout = {3'b000, i_wager};
    else
      w_payout = {3'b000, i_wager} * {{WIDTH{1'b0}}, i_code};
  end

  assign w_res    = sat_add(SAT_W'(i_mih), SAT_W'(w_payout), WIDTH);
  assign o_mih    = w_res.sum[WIDTH-1:0];
  assign o_sat    = w_res.sat;
  assign w_unused = ^w_res.sum[SAT_W-1:WIDTH];

endmodule

// File: rtl/wager_bank.sv
// rtl/wager_bank.sv - player balance and wager state machine for one betting round
module wager_bank
  import wager_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int STEP       = 10,
  parameter int MIN_BET    = 10,
  parameter int MAX_BET    = 1000,
  parameter int INIT_MONEY = 100
) (
  input  logic             clock,
  input  logic             reset_c,
  input  logic             bet_s,
  input  logic [1:0]       updown,
  input  logic             deal_s,
  input  logic             result_v,
  input  logic [2:0]       result_code,
  input  logic             load_s,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] wager_o,
  output logic [WIDTH-1:0] mih_o,
  output logic [1:0]       state_o,
  output logic             broke_o,
  output logic             sat_o
);

  if (MIN_BET <= 0) begin : g_bad_min
    $error("wager_bank: MIN_BET must be positive");
  end
  if (STEP <= 0) begin : g_bad_step
    $error("wager_bank: STEP must be positive");
  end
  if (MAX_BET < MIN_BET) begin : g_bad_max
    $error("wager_bank: MAX_BET must be >= MIN_BET");
  end
  if (WIDTH < 2 || WIDTH > SAT_W - 4) begin : g_bad_width
    $error("wager_bank: WIDTH out of range");
  end else if (INIT_MONEY >= (1 << WIDTH) || MAX_BET >= (1 << WIDTH)) begin : g_bad_init
    $error("wager_bank: INIT_MONEY and MAX_BET must fit in WIDTH bits");
  end

  localparam logic [WIDTH-1:0] LP_MIN    = WIDTH'(MIN_BET);
  localparam logic [WIDTH-1:0] LP_MAX    = WIDTH'(MAX_BET);
  localparam logic [WIDTH-1:0] LP_STEP   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] LP_INIT   = WIDTH'(INIT_MONEY);
  localparam logic [WIDTH:0]   LP_MIN_UP = (WIDTH+1)'(MIN_BET + STEP);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_wager, w_wager_nxt;
  logic [WIDTH-1:0] r_mih, w_mih_nxt;
  logic             r_sat, w_sat_nxt;
  logic [2:0]       r_code, w_code_nxt;
  logic             r_broke, w_broke_nxt;

  logic [WIDTH-1:0] w_cap;
  logic             w_deal_ok;
  logic [WIDTH:0]   w_up;
  logic [WIDTH-1:0] w_adj;
  logic [WIDTH-1:0] w_pay_mih;
  logic             w_pay_sat;
  sat_res_t         w_load;
  logic             w_unused;

  assign w_cap     = (r_mih > LP_MAX) ? LP_MAX : r_mih;
  assign w_deal_ok = (r_mih >= LP_MIN) && (r_wager >= LP_MIN) && (r_wager <= w_cap);
  assign w_up      = {1'b0, r_wager} + {1'b0, LP_STEP};
  assign w_load    = sat_add(SAT_W'(r_mih), SAT_W'(load_val), WIDTH);
  assign w_unused  = ^w_load.sum[SAT_W-1:WIDTH];

  wager_payout_calc #(.WIDTH(WIDTH)) u_payout (
    .i_mih   (r_mih),
    .i_wager (r_wager),
    .i_code  (r_code),
    .o_mih   (w_pay_mih),
    .o_sat   (w_pay_sat)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_wager_nxt = r_wager;
    w_mih_nxt   = r_mih;
    w_sat_nxt   = r_sat;
    w_code_nxt  = r_code;
    w_adj       = r_wager;
    case (r_state)
      ST_BET: begin
        if (deal_s && w_deal_ok) begin
          w_mih_nxt   = r_mih - r_wager;
          w_state_nxt = ST_LOCKED;
        end else begin
          // A rejected deal still blocks updown and load for this cycle.
          if (bet_s && !deal_s) begin
            if (updown == 2'b01)
              w_adj = (w_up > {1'b0, w_cap}) ? w_cap : w_up[WIDTH-1:0];
            else if (updown == 2'b10)
              w_adj = ({1'b0, r_wager} < LP_MIN_UP) ? LP_MIN : r_wager - LP_STEP;
          end
          if (w_cap < LP_MIN)
            w_wager_nxt = LP_MIN;
          else if (w_adj > w_cap)
            w_wager_nxt = w_cap;
          else
            w_wager_nxt = w_adj;
          if (load_s && !deal_s) begin
            w_mih_nxt = w_load.sum[WIDTH-1:0];
            w_sat_nxt = r_sat | w_load.sat;
          end
        end
      end
      ST_LOCKED: begin
        if (result_v) begin
          w_code_nxt  = result_code;
          w_state_nxt = ST_PAYOUT;
        end
      end
      ST_PAYOUT: begin
        w_mih_nxt   = w_pay_mih;
        w_sat_nxt   = r_sat | w_pay_sat;
        w_state_nxt = ST_BET;
      end
      default: w_state_nxt = ST_BET;
    endcase
    w_broke_nxt = (w_state_nxt == ST_BET) && (w_mih_nxt < LP_MIN);
  end

  always_ff @(posedge clock) begin
    if (reset_c) begin
      r_state <= ST_BET;
      r_wager <= LP_MIN;
      r_mih   <= LP_INIT;
      r_sat   <= 1'b0;
      r_code  <= RES_LOSE;
      r_broke <= (LP_INIT < LP_MIN);
    end else begin
      r_state <= w_state_nxt;
      r_wager <= w_wager_nxt;
      r_mih   <= w_mih_nxt;
      r_sat   <= w_sat_nxt;
      r_code  <= w_code_nxt;
      r_broke <= w_broke_nxt;
    end
  end

  assign wager_o = r_wager;
  assign mih_o   = r_mih;
  assign state_o = r_state;
  assign broke_o = r_broke;
  assign sat_o   = r_sat;

endmodule

// File: tb/tb_wager_bank.sv
// tb/tb_wager_bank.sv - scoreboard bench for wager_bank with directed vectors
module tb_wager_bank;

  logic        clock = 1'b0;
  logic        reset_c = 1'b0;
  logic        bet_s = 1'b0;
  logic [1:0]  updown = 2'b00;
  logic        deal_s = 1'b0;
  logic        result_v = 1'b0;
  logic [2:0]  result_code = 3'd0;
  logic        load_s = 1'b0;
  logic [15:0] load_val = 16'd0;
  logic [15:0] wager_o;
  logic [15:0] mih_o;
  logic [1:0]  state_o;
  logic        broke_o;
  logic        sat_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string nm;
    int    w;
    int    m;
    int    s;
    int    b;
    int    sat;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  wager_bank dut (
    .clock       (clock),
    .reset_c     (reset_c),
    .bet_s       (bet_s),
    .updown      (updown),
    .deal_s      (deal_s),
    .result_v    (result_v),
    .result_code (result_code),
    .load_s      (load_s),
    .load_val    (load_val),
    .wager_o     (wager_o),
    .mih_o       (mih_o),
    .state_o     (state_o),
    .broke_o     (broke_o),
    .sat_o       (sat_o)
  );

  // Monitor: outputs after each active edge are compared on the following falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (int'(wager_o) != e.w || int'(mih_o) != e.m || int'(state_o) != e.s ||
            int'(broke_o) != e.b || int'(sat_o) != e.sat) begin
          n_fail++;
          $display("FAIL %s: got wager=%0d mih=%0d state=%0d broke=%0d sat=%0d, want wager=%0d mih=%0d state=%0d broke=%0d sat=%0d",
                   e.nm, wager_o, mih_o, state_o, broke_o, sat_o, e.w, e.m, e.s, e.b, e.sat);
        end
      end
    end
  end

  task automatic t(input bit rst, input bit bet, input logic [1:0] ud, input bit deal,
                   input bit rv, input logic [2:0] code, input bit ld, input int lval,
                   input string nm, input int ew, input int em, input int es,
                   input int eb, input int esat);
    exp_t e;
    @(negedge clock);
    reset_c     = rst;
    bet_s       = bet;
    updown      = ud;
    deal_s      = deal;
    result_v    = rv;
    result_code = code;
    load_s      = ld;
    load_val    = 16'(lval);
    @(posedge clock);
    e.nm = nm; e.w = ew; e.m = em; e.s = es; e.b = eb; e.sat = esat;
    sb.push_back(e);
  endtask

  initial begin
    t(1, 0, 2'b00, 0, 0, 3'd0, 0, 0, "reset", 10, 100, 0, 0, 0);
    for (int i = 1; i <= 11; i++)
      t(0, 1, 2'b01, 0, 0, 3'd0, 0, 0, "ramp_up", (10 + 10*i > 100) ? 100 : 10 + 10*i, 100, 0, 0, 0);
    for (int i = 1; i <= 12; i++)
      t(0, 1, 2'b10, 0, 0, 3'd0, 0, 0, "ramp_down", (100 - 10*i < 10) ? 10 : 100 - 10*i, 100, 0, 0, 0);
    t(0, 1, 2'b00, 0, 0, 3'd0, 1, 35, "load35", 10, 135, 0, 0, 0);
    for (int i = 1; i <= 13; i++)
      t(0, 1, 2'b01, 0, 0, 3'd0, 0, 0, "cap_clamp", (10 + 10*i > 135) ? 135 : 10 + 10*i, 135, 0, 0, 0);
    t(0, 1, 2'b00, 1, 0, 3'd0, 0, 0, "deal_all", 135, 0, 1, 0, 0);
    t(0, 1, 2'b01, 1, 0, 3'd0, 1, 500, "locked_ignore", 135, 0, 1, 0, 0);
    t(0, 0, 2'b00, 0, 1, 3'd0, 0, 0, "res_lose", 135, 0, 2, 0, 0);
    t(0, 0, 2'b00, 0, 0, 3'd0, 0, 0, "pay_lose", 135, 0, 0, 1, 0);
    t(0, 0, 2'b00, 0, 0, 3'd0, 0, 0, "clamp_broke", 10, 0, 0, 1, 0);
    t(0, 1, 2'b00, 0, 0, 3'd0, 1, 5, "load5", 10, 5, 0, 1, 0);
    t(0, 1, 2'b01, 1, 0, 3'd0, 0, 0, "deal_broke", 10, 5, 0, 1, 0);
    t(0, 1, 2'b00, 0, 0, 3'd0, 1, 95, "load95", 10, 100, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      t(0, 1, 2'b01, 0, 0, 3'd0, 0, 0, "up_to50", 10 + 10*i, 100, 0, 0, 0);
    t(0, 0, 2'b00, 1, 0, 3'd0, 0, 0, "deal_nobet", 50, 50, 1, 0, 0);
    t(0, 0, 2'b00, 0, 1, 3'd3, 0, 0, "res3", 50, 50, 2, 0, 0);
    t(0, 0, 2'b00, 0, 0, 3'd0, 0, 0, "pay3", 50, 200, 0, 0, 0);
    t(0, 0, 2'b00, 1, 0, 3'd0, 0, 0, "deal50", 50, 150, 1, 0, 0);
    t(0, 0, 2'b00, 0, 1, 3'd1, 0, 0, "res_push", 50, 150, 2, 0, 0);
    t(0, 0, 2'b00, 0, 0, 3'd0, 0, 0, "pay_push", 50, 200, 0, 0, 0);
    for (int i = 1; i <= 3; i++)
      t(0, 1, 2'b10, 0, 0, 3'd0, 0, 0, "down_to20", 50 - 10*i, 200, 0, 0, 0);
    t(0, 1, 2'b01, 1, 0, 3'd0, 1, 7, "deal_plus_up", 20, 180, 1, 0, 0);
    t(0, 0, 2'b00, 0, 1, 3'd0, 0, 0, "res_lose2", 20, 180, 2, 0, 0);
    t(0, 0, 2'b00, 0, 0, 3'd0, 0, 0, "pay_lose2", 20, 180, 0, 0, 0);
    t(0, 0, 2'b00, 0, 1, 3'd7, 0, 0, "rv_in_bet", 20, 180, 0, 0, 0);
    t(0, 1, 2'b01, 0, 0, 3'd0, 0, 0, "up30", 30, 180, 0, 0, 0);
    t(0, 1, 2'b01, 0, 0, 3'd0, 0, 0, "up40", 40, 180, 0, 0, 0);
    t(0, 0, 2'b00, 1, 0, 3'd0, 0, 0, "deal40", 40, 140, 1, 0, 0);
    t(1, 0, 2'b00, 0, 0, 3'd0, 0, 0, "reset_locked", 10, 100, 0, 0, 0);
    t(0, 1, 2'b00, 0, 0, 3'd0, 1, 65000, "load_big", 10, 65100, 0, 0, 0);
    for (int i = 1; i <= 100; i++)
      t(0, 1, 2'b01, 0, 0, 3'd0, 0, 0, "up_to_max", (10 + 10*i > 1000) ? 1000 : 10 + 10*i, 65100, 0, 0, 0);
    t(0, 1, 2'b01, 0, 0, 3'd0, 0, 0, "max_bet_hold", 1000, 65100, 0, 0, 0);
    t(0, 0, 2'b00, 1, 0, 3'd0, 0, 0, "deal1000", 1000, 64100, 1, 0, 0);
    t(0, 0, 2'b00, 0, 1, 3'd7, 0, 0, "res7", 1000, 64100, 2, 0, 0);
    t(0, 0, 2'b00, 0, 0, 3'd0, 0, 0, "pay_sat", 1000, 65535, 0, 0, 1);
    t(0, 0, 2'b00, 1, 0, 3'd0, 0, 0, "deal_again", 1000, 64535, 1, 0, 1);
    t(0, 0, 2'b00, 0, 1, 3'd0, 0, 0, "res_lose3", 1000, 64535, 2, 0, 1);
    t(0, 0, 2'b00, 0, 0, 3'd0, 0, 0, "sat_sticky", 1000, 64535, 0, 0, 1);
    t(1, 0, 2'b00, 0, 0, 3'd0, 0, 0, "reset_sat", 10, 100, 0, 0, 0);
    t(0, 1, 2'b00, 0, 0, 3'd0, 1, 65535, "load_sat", 10, 65535, 0, 0, 1);
    t(0, 0, 2'b00, 0, 0, 3'd0, 0, 0, "idle_end", 10, 65535, 0, 0, 1);

    @(negedge clock);
    reset_c = 1'b0; bet_s = 1'b0; updown = 2'b00; deal_s = 1'b0;
    result_v = 1'b0; load_s = 1'b0; load_val = 16'd0;
    for (int k = 0; k < 10 && sb.size() > 0; k++)
      @(negedge clock);
    #1;
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
